// File: rtl/masked_sbox_scheduler.sv
// Time-multiplexes a pool of pipelined masked GF(2^8) inverter lanes between
// a 16-byte masked round state and a 4-byte masked key-schedule word.
// A job is split into beats of NUM_LANES bytes. Each beat is pushed into the
// free-running lanes. A tag shift register follows each beat through the
// pipeline so its result bytes can be written back to the correct slot.
module masked_sbox_scheduler #(
    parameter int NUM_SHARES = 2,
    parameter int NUM_LANES  = 4,
    parameter int LATENCY    = 3
) (
    input  logic                              in_clock,
    input  logic                              in_reset,
    input  logic                              in_state_valid,
    output logic                              out_state_ready,
    input  logic [16*8*NUM_SHARES-1:0]        in_state,
    input  logic                              in_key_valid,
    output logic                              out_key_ready,
    input  logic [4*8*NUM_SHARES-1:0]         in_key,
    input  logic                              in_random_valid,
    output logic                              out_random_ready,
    output logic [NUM_LANES*8*NUM_SHARES-1:0] out_sbox_in,
    input  logic [NUM_LANES*8*NUM_SHARES-1:0] in_sbox_out,
    output logic                              out_state_valid,
    input  logic                              in_state_ready,
    output logic [16*8*NUM_SHARES-1:0]        out_state,
    output logic                              out_key_valid,
    input  logic                              in_key_ready,
    output logic [4*8*NUM_SHARES-1:0]         out_key,
    output logic                              out_busy
);
    localparam int SW        = 8 * NUM_SHARES;
    localparam int LANE_W    = NUM_LANES * SW;
    localparam int STATE_W   = 16 * SW;
    localparam int KEY_W     = 4 * SW;
    localparam int MAX_BEATS = 16 / NUM_LANES;
    localparam int KEY_BEATS = 4 / NUM_LANES;
    localparam int CW        = $clog2(MAX_BEATS + 1);
    localparam int BW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t               state_r;
    state_t               state_s;
    logic                 job_key_r;
    logic [CW-1:0]        beats_r;
    logic [CW-1:0]        beat_cnt_r;
    logic [STATE_W-1:0]   in_buf_r;
    logic [STATE_W-1:0]   res_r;
    logic [LATENCY-1:0]   tag_valid_r;
    logic [BW-1:0]        tag_beat_r [LATENCY];

    logic                 accept_key_s;
    logic                 accept_state_s;
    logic                 issue_s;
    logic                 upstream_s;
    logic                 last_retire_s;
    logic                 release_s;

    // Tags still travelling ahead of the output stage; the last retire is when only the output tag is valid
    always_comb begin
        upstream_s = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            upstream_s = upstream_s | tag_valid_r[i];
        end
        last_retire_s = tag_valid_r[LATENCY-1] & ~upstream_s;
        release_s     = job_key_r ? in_key_ready : in_state_ready;
    end

    // Next-state logic: job acceptance with key priority, beat issue, drain, result handshake
    always_comb begin
        state_s        = state_r;
        accept_key_s   = 1'b0;
        accept_state_s = 1'b0;
        issue_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_key_valid) begin
                    accept_key_s = 1'b1;
                    state_s      = ISSUE;
                end else if (in_state_valid) begin
                    accept_state_s = 1'b1;
                    state_s        = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (in_random_valid) begin
                    issue_s = 1'b1;
                    if (beat_cnt_r == (beats_r - CW'(1))) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = ISSUE;
                end
            end
            DRAIN: begin
                if (last_retire_s) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE: begin
                if (release_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job bookkeeping: capture the job on accept, advance the beat counter on each issue
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            job_key_r  <= 1'b0;
            beats_r    <= '0;
            beat_cnt_r <= '0;
            in_buf_r   <= '0;
        end else if (accept_key_s) begin
            job_key_r  <= 1'b1;
            beats_r    <= CW'(KEY_BEATS);
            beat_cnt_r <= '0;
            in_buf_r   <= {{(STATE_W - KEY_W){1'b0}}, in_key};
        end else if (accept_state_s) begin
            job_key_r  <= 1'b0;
            beats_r    <= CW'(MAX_BEATS);
            beat_cnt_r <= '0;
            in_buf_r   <= in_state;
        end else if (issue_s) begin
            beat_cnt_r <= beat_cnt_r + CW'(1);
        end
    end

    // Tag pipeline shadows the lanes, which have no enable, so it shifts every cycle
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            tag_valid_r <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_beat_r[i] <= '0;
            end
        end else begin
            tag_valid_r[0] <= issue_s;
            tag_beat_r[0]  <= beat_cnt_r[BW-1:0];
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_beat_r[i]  <= tag_beat_r[i-1];
            end
        end
    end

    // Result reassembly: a valid tag at the lane output selects the destination beat slot
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            res_r <= '0;
        end else if (tag_valid_r[LATENCY-1]) begin
            res_r[tag_beat_r[LATENCY-1]*LANE_W +: LANE_W] <= in_sbox_out;
        end
    end

    // Output decode: lanes see data only on issue, results are exposed only in DONE for the matching job
    always_comb begin
        out_key_ready    = in_reset & accept_key_s;
        out_state_ready  = in_reset & accept_state_s;
        out_random_ready = issue_s | (|tag_valid_r);
        out_busy         = (state_r != IDLE);
        out_key_valid    = 1'b0;
        out_state_valid  = 1'b0;
        out_key          = '0;
        out_state        = '0;
        if (issue_s) begin
            out_sbox_in = in_buf_r[beat_cnt_r*LANE_W +: LANE_W];
        end else begin
            out_sbox_in = '0;
        end
        if (state_r == DONE) begin
            if (job_key_r) begin
                out_key_valid = 1'b1;
                out_key       = res_r[KEY_W-1:0];
            end else begin
                out_state_valid = 1'b1;
                out_state       = res_r;
            end
        end else begin
            out_key_valid   = 1'b0;
            out_state_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_masked_sbox_scheduler.sv
// Bench for masked_sbox_scheduler: directed vector table, hand-written
// multi-cycle sequences and randomized jobs. The inverter lanes are modelled
// here as a LATENCY-deep pipeline whose share 0 carries inv(x) re-masked with
// the incoming upper shares, so every expected output share is exactly known.
module tb_masked_sbox_scheduler;
    localparam int NUM_SHARES = 2;
    localparam int NUM_LANES  = 4;
    localparam int LATENCY    = 3;
    localparam int SW         = 8 * NUM_SHARES;
    localparam int LANE_W     = NUM_LANES * SW;
    localparam int W          = 16 * SW;
    localparam int KEY_W      = 4 * SW;

    logic              in_clock = 1'b0;
    logic              in_reset = 1'b0;
    logic              in_state_valid = 1'b0;
    logic              out_state_ready;
    logic [W-1:0]      in_state = '0;
    logic              in_key_valid = 1'b0;
    logic              out_key_ready;
    logic [KEY_W-1:0]  in_key = '0;
    logic              in_random_valid = 1'b0;
    logic              out_random_ready;
    logic [LANE_W-1:0] out_sbox_in;
    logic [LANE_W-1:0] in_sbox_out;
    logic              out_state_valid;
    logic              in_state_ready = 1'b0;
    logic [W-1:0]      out_state;
    logic              out_key_valid;
    logic              in_key_ready = 1'b0;
    logic [KEY_W-1:0]  out_key;
    logic              out_busy;

    always #5 in_clock = ~in_clock;

    masked_sbox_scheduler #(
        .NUM_SHARES(NUM_SHARES), .NUM_LANES(NUM_LANES), .LATENCY(LATENCY)
    ) dut (
        .in_clock(in_clock), .in_reset(in_reset),
        .in_state_valid(in_state_valid), .out_state_ready(out_state_ready), .in_state(in_state),
        .in_key_valid(in_key_valid), .out_key_ready(out_key_ready), .in_key(in_key),
        .in_random_valid(in_random_valid), .out_random_ready(out_random_ready),
        .out_sbox_in(out_sbox_in), .in_sbox_out(in_sbox_out),
        .out_state_valid(out_state_valid), .in_state_ready(in_state_ready), .out_state(out_state),
        .out_key_valid(out_key_valid), .in_key_ready(in_key_ready), .out_key(out_key),
        .out_busy(out_busy)
    );

    logic [7:0]        inv_tab [256];
    logic [LANE_W-1:0] pipe [LATENCY];
    int                n_cmp = 0;
    int                n_bad = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            bb = bb >> 1;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
        end
        return p;
    endfunction

    // One masked byte through an ideal inverter: unmask, invert, re-mask with the upper shares
    function automatic logic [SW-1:0] lane_byte(input logic [SW-1:0] sh);
        logic [7:0]    x;
        logic [SW-1:0] o;
        x = 8'h00;
        for (int s = 0; s < NUM_SHARES; s++) x = x ^ sh[s*8 +: 8];
        o = sh;
        o[7:0] = inv_tab[x] ^ x ^ sh[7:0];
        return o;
    endfunction

    function automatic logic [LANE_W-1:0] map_lane(input logic [LANE_W-1:0] v);
        logic [LANE_W-1:0] o;
        for (int i = 0; i < NUM_LANES; i++) o[i*SW +: SW] = lane_byte(v[i*SW +: SW]);
        return o;
    endfunction

    function automatic logic [W-1:0] map_bytes(input logic [W-1:0] v);
        logic [W-1:0] o;
        for (int i = 0; i < 16; i++) o[i*SW +: SW] = lane_byte(v[i*SW +: SW]);
        return o;
    endfunction

    function automatic logic [W-1:0] mask_bytes(input logic [127:0] plain, input int nb);
        logic [W-1:0] v;
        logic [7:0]   acc;
        v = '0;
        for (int i = 0; i < nb; i++) begin
            acc = plain[i*8 +: 8];
            for (int s = 1; s < NUM_SHARES; s++) begin
                v[i*SW + s*8 +: 8] = 8'($urandom);
                acc = acc ^ v[i*SW + s*8 +: 8];
            end
            v[i*SW +: 8] = acc;
        end
        return v;
    endfunction

    function automatic logic [127:0] unmask(input logic [W-1:0] v);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < 16; i++)
            for (int s = 0; s < NUM_SHARES; s++) p[i*8 +: 8] = p[i*8 +: 8] ^ v[i*SW + s*8 +: 8];
        return p;
    endfunction

    // Inverter lanes: fixed LATENCY pipeline with no enable
    always @(posedge in_clock) begin
        pipe[0] <= map_lane(out_sbox_in);
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign in_sbox_out = pipe[LATENCY-1];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Runs one job from offer to result handshake, checking every cycle against the schedule
    // implied by the random-valid pattern rv (bit c = in_random_valid in cycle c after accept).
    task automatic do_job(input bit is_key, input logic [127:0] plain, input logic [127:0] exp_plain,
                          input logic [127:0] rv, input int bp, input int want_v, input string tag);
        int           nb, beats, k, last, v_exp;
        bit           iss [128];
        bit           rr;
        logic [W-1:0] data, exp_res;
        nb = is_key ? 4 : 16;
        beats = nb / NUM_LANES;
        data = mask_bytes(plain, nb);
        exp_res = map_bytes(data);
        k = 0; last = 0;
        for (int c = 0; c < 128; c++) begin
            iss[c] = (c >= 1) && rv[c] && (k < beats);
            if (iss[c]) begin k++; last = c; end
        end
        v_exp = (want_v != 0) ? want_v : last + LATENCY + 1;
        if (is_key) begin in_key_valid = 1'b1; in_key = data[KEY_W-1:0]; end
        else begin in_state_valid = 1'b1; in_state = data; end
        in_random_valid = rv[0];
        @(negedge in_clock);
        chk({tag, " idle_busy"}, W'(out_busy), W'(0));
        chk({tag, " key_ready"}, W'(out_key_ready), W'(is_key));
        chk({tag, " state_ready"}, W'(out_state_ready), W'(!is_key));
        @(posedge in_clock); #1;
        in_key_valid = 1'b0; in_state_valid = 1'b0;
        k = 0;
        for (int c = 1; c <= v_exp + bp; c++) begin
            in_random_valid = rv[c];
            in_key_ready    = is_key ? (c >= v_exp + bp) : 1'b1;
            in_state_ready  = is_key ? 1'b1 : (c >= v_exp + bp);
            in_key_valid    = (c >= v_exp) && (c < v_exp + bp);
            in_state_valid  = (c >= v_exp) && (c < v_exp + bp);
            @(negedge in_clock);
            rr = iss[c];
            for (int j = 1; j <= LATENCY; j++) if (c - j >= 1) rr = rr | iss[c-j];
            chk({tag, " busy"}, W'(out_busy), W'(1));
            chk({tag, " no_accept"}, W'({out_key_ready, out_state_ready}), W'(0));
            chk({tag, " sbox_in"}, W'(out_sbox_in), iss[c] ? W'(data[k*LANE_W +: LANE_W]) : W'(0));
            chk({tag, " random_ready"}, W'(out_random_ready), W'(rr));
            chk({tag, " key_valid"}, W'(out_key_valid), W'(is_key && (c >= v_exp)));
            chk({tag, " state_valid"}, W'(out_state_valid), W'(!is_key && (c >= v_exp)));
            if (c >= v_exp) begin
                if (is_key) chk({tag, " key_result"}, W'(out_key), W'(exp_res[KEY_W-1:0]));
                else        chk({tag, " state_result"}, out_state, exp_res);
            end
            if (c == v_exp) begin
                if (is_key) chk({tag, " key_unmasked"}, W'(unmask(W'(out_key))), W'(exp_plain));
                else        chk({tag, " state_unmasked"}, W'(unmask(out_state)), W'(exp_plain));
            end
            if (iss[c]) k++;
            @(posedge in_clock); #1;
        end
        in_key_ready = 1'b0; in_state_ready = 1'b0;
        in_key_valid = 1'b0; in_state_valid = 1'b0;
        @(negedge in_clock);
        chk({tag, " back_idle"}, W'({out_busy, out_random_ready, out_key_valid, out_state_valid}), W'(0));
        @(posedge in_clock); #1;
    endtask

    typedef struct {
        bit           is_key;
        logic [127:0] plain;
        logic [127:0] exp_plain;
        logic [127:0] rv;
        int           bp;
        int           want_v;
    } vec_t;

    vec_t         vecs [6];
    logic [127:0] all1;
    logic [127:0] stall;
    logic [W-1:0] kd, sd, kres, sres;
    int           kc, src, sv;
    bit           kk;
    logic [127:0] p, e, rvr;
    int           bpr;

    initial begin
        for (int x = 0; x < 256; x++) begin
            inv_tab[x] = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv_tab[x] = 8'(y);
        end
        all1  = {128{1'b1}};
        stall = all1; stall[2] = 1'b0; stall[3] = 1'b0;
        vecs[0] = '{1'b1, 128'hCA530100, 128'h53CA0100, all1, 0, 5};
        vecs[1] = '{1'b1, 128'h01530302, 128'h01CAF68D, all1, 2, 5};
        vecs[2] = '{1'b1, 128'h00F68DCA, 128'h00030253, all1, 0, 5};
        vecs[3] = '{1'b0, 128'h0F0E0D0C0B0A09080706050403020100,
                          128'hC7E5E1B0C0294FE8D17B52CBF68D0100, all1, 0, 8};
        vecs[4] = '{1'b0, 128'h0F0E0D0C0B0A09080706050403020100,
                          128'hC7E5E1B0C0294FE8D17B52CBF68D0100, stall, 0, 10};
        vecs[5] = '{1'b0, 128'h0F0E0D0C0B0A09080706050403020100,
                          128'hC7E5E1B0C0294FE8D17B52CBF68D0100, all1, 5, 8};

        // reset state
        repeat (3) @(posedge in_clock);
        @(negedge in_clock);
        chk("reset_ctrl", W'({out_busy, out_key_valid, out_state_valid, out_random_ready,
                              out_key_ready, out_state_ready}), W'(0));
        chk("reset_sbox_in", W'(out_sbox_in), W'(0));
        chk("reset_out_state", out_state, W'(0));
        @(posedge in_clock); #1;
        in_reset = 1'b1;
        @(posedge in_clock); #1;

        // directed vector table
        for (int v = 0; v < 6; v++)
            do_job(vecs[v].is_key, vecs[v].plain, vecs[v].exp_plain, vecs[v].rv,
                   vecs[v].bp, vecs[v].want_v, $sformatf("vec%0d", v));

        // simultaneous offers: key first, state in the first IDLE cycle after the key handshake
        kd = mask_bytes(128'hCA530100, 4);
        sd = mask_bytes(128'h0F0E0D0C0B0A09080706050403020100, 16);
        kres = map_bytes(kd); sres = map_bytes(sd);
        in_key = kd[KEY_W-1:0]; in_key_valid = 1'b1;
        in_state = sd; in_state_valid = 1'b1; in_random_valid = 1'b1;
        @(negedge in_clock);
        chk("sim key_ready", W'(out_key_ready), W'(1));
        chk("sim state_ready", W'(out_state_ready), W'(0));
        @(posedge in_clock); #1;
        in_key_valid = 1'b0;
        kc = 0; src = 0; sv = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge in_clock);
            if (out_key_valid && kc == 0) begin
                kc = c;
                chk("sim key_result", W'(out_key), W'(kres[KEY_W-1:0]));
            end
            if (out_state_ready && src == 0) src = c;
            if (out_state_valid && sv == 0) begin
                sv = c;
                chk("sim state_result", out_state, sres);
            end
            in_key_ready = out_key_valid; in_state_ready = out_state_valid;
            @(posedge in_clock); #1;
            if (src != 0) in_state_valid = 1'b0;
            in_key_ready = 1'b0; in_state_ready = 1'b0;
        end
        chk("sim key_valid_cycle", W'(kc), W'(5));
        chk("sim state_accept_cycle", W'(src), W'(6));
        chk("sim state_valid_cycle", W'(sv), W'(14));

        // reset in cycle 3 of a state job, then a fresh key job
        sd = mask_bytes({$urandom, $urandom, $urandom, $urandom}, 16);
        in_state = sd; in_state_valid = 1'b1; in_random_valid = 1'b1;
        @(posedge in_clock); #1;
        in_state_valid = 1'b0;
        @(posedge in_clock); #1;
        @(posedge in_clock); #1;
        in_reset = 1'b0;
        #1;
        chk("midrst ctrl", W'({out_busy, out_key_valid, out_state_valid, out_random_ready,
                               out_key_ready, out_state_ready}), W'(0));
        chk("midrst sbox_in", W'(out_sbox_in), W'(0));
        chk("midrst out_key", W'(out_key), W'(0));
        chk("midrst out_state", out_state, W'(0));
        repeat (2) @(posedge in_clock);
        #1 in_reset = 1'b1;
        @(negedge in_clock);
        chk("postrst out_state", out_state, W'(0));
        chk("postrst busy", W'(out_busy), W'(0));
        @(posedge in_clock); #1;
        do_job(1'b1, 128'hCA530100, 128'h53CA0100, all1, 1, 5, "postrst_key");
        @(negedge in_clock);
        chk("postrst no_stale_state", out_state, W'(0));
        chk("postrst no_state_valid", W'(out_state_valid), W'(0));
        @(posedge in_clock); #1;

        // randomized jobs against the bench reference
        for (int j = 0; j < 24; j++) begin
            kk = 1'($urandom_range(0, 1));
            p = {$urandom, $urandom, $urandom, $urandom};
            if (kk) p[127:32] = '0;
            e = '0;
            for (int i = 0; i < 16; i++) e[i*8 +: 8] = inv_tab[p[i*8 +: 8]];
            rvr = all1;
            for (int c = 0; c < 24; c++) rvr[c] = ($urandom_range(0, 3) != 0);
            bpr = $urandom_range(0, 3);
            do_job(kk, p, e, rvr, bpr, 0, $sformatf("rand%0d", j));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
